// File: rtl/tdm_demux_4.sv
// tdm_demux_4: receive side of a 4-slot TDM link. Tracks slot position
// against a frame-sync marker, collects slots 0..2 in holding registers and
// commits all four channel outputs together when slot 3 arrives.
module tdm_demux_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);

  // Input handshake: there is no back-pressure. A sample is consumed on every
  // rising edge where din_valid=1; din and fsync are don't-care otherwise and
  // an idle cycle leaves all state untouched.

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] h2;
  logic [WIDTH-1:0] h3;

  // locked is the FSM state itself, so it doubles as the state observation port.
  assign locked = (state == LOCKED);

  // Slot tracking, holding registers, atomic frame commit and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= 2'd0;
      h1         <= '0;
      h2         <= '0;
      h3         <= '0;
      o1         <= '0;
      o2         <= '0;
      o3         <= '0;
      o4         <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle; idle cycles always clear them.
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            // Samples without sync are silently dropped while hunting.
            if (fsync) begin
              h1    <= din;
              slot  <= 2'd1;
              state <= LOCKED;
            end
          end
          default: begin
            if (fsync) begin
              // Sync always restarts a frame; mid-frame it discards the
              // partial frame and flags the violation.
              h1   <= din;
              slot <= 2'd1;
              if (slot != 2'd0) sync_err <= 1'b1;
            end else begin
              case (slot)
                2'd0: begin
                  // Expected a sync marker: alignment is lost.
                  sync_err <= 1'b1;
                  slot     <= 2'd0;
                  state    <= HUNT;
                end
                2'd1: begin
                  h2   <= din;
                  slot <= 2'd2;
                end
                2'd2: begin
                  h3   <= din;
                  slot <= 2'd3;
                end
                default: begin
                  // Final slot: all four outputs change on the same edge.
                  o1         <= h1;
                  o2         <= h2;
                  o3         <= h3;
                  o4         <= din;
                  frame_done <= 1'b1;
                  slot       <= 2'd0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4 (WIDTH=8).
module tb_tdm_demux_4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       fsync;
  logic [7:0] o1, o2, o3, o4;
  logic [1:0] slot;
  logic       locked;
  logic       frame_done;
  logic       sync_err;

  int n_cmp;
  int n_fail;

  tdm_demux_4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .o4         (o4),
    .slot       (slot),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one valid sample at the falling edge; return #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic fs);
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    fsync     = fs;
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with deliberately noisy din/fsync.
  task automatic idle();
    @(negedge clk);
    din       = 8'hEE;
    din_valid = 1'b0;
    fsync     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    fsync     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({o1, o2, o3, o4} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=%h", {o1, o2, o3, o4}, 32'h0);
    end
    n_cmp++;
    if ({locked, slot, frame_done, sync_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status got=%b want=%b", {locked, slot, frame_done, sync_err}, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    send(8'hA0, 1'b1);
    n_cmp++;
    if ({locked, slot, frame_done, sync_err} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_after_a0 got=%b want=%b", {locked, slot, frame_done, sync_err}, 5'b10100);
    end
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4, frame_done} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_no_early_commit got=%h fd=%b want=0", {o1, o2, o3, o4}, frame_done);
    end
    send(8'hA3, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4} !== 32'hA0A1A2A3) begin
      n_fail++;
      $display("FAIL basic_commit got=%h want=%h", {o1, o2, o3, o4}, 32'hA0A1A2A3);
    end
    n_cmp++;
    if ({locked, slot, frame_done, sync_err} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_commit_status got=%b want=%b", {locked, slot, frame_done, sync_err}, 5'b10010);
    end
    idle();
    n_cmp++;
    if ({frame_done, o1, o2, o3, o4} !== {1'b0, 32'hA0A1A2A3}) begin
      n_fail++;
      $display("FAIL basic_pulse_width got fd=%b o=%h want fd=0 o=a0a1a2a3", frame_done, {o1, o2, o3, o4});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [8];
    int         fd_count;
    int         gap;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      send(vals[i], (i % 4) == 0);
      if (frame_done) fd_count++;
      if (i >= 4 && i < 7) begin
        n_cmp++;
        if ({o1, o2, o3, o4} !== 32'h11223344) begin
          n_fail++;
          $display("FAIL b2b_hold idx=%0d got=%h want=%h", i, {o1, o2, o3, o4}, 32'h11223344);
        end
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        idle();
        if (frame_done) fd_count++;
      end
    end
    n_cmp++;
    if ({o1, o2, o3, o4} !== 32'h55667788) begin
      n_fail++;
      $display("FAIL b2b_second_frame got=%h want=%h", {o1, o2, o3, o4}, 32'h55667788);
    end
    n_cmp++;
    if (fd_count !== 2) begin
      n_fail++;
      $display("FAIL b2b_frame_done_count got=%0d want=2", fd_count);
    end
  endtask

  task automatic test_hunt();
    int err_seen;
    test_reset();
    err_seen = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'hF0 + 8'(i), 1'b0);
      if (sync_err || locked || slot != 2'd0) err_seen++;
    end
    n_cmp++;
    if (err_seen !== 0) begin
      n_fail++;
      $display("FAIL hunt_drop got=%0d bad cycles want=0", err_seen);
    end
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4, frame_done} !== {32'h01020304, 1'b1}) begin
      n_fail++;
      $display("FAIL hunt_frame got=%h fd=%b want=01020304 fd=1", {o1, o2, o3, o4}, frame_done);
    end
  endtask

  task automatic test_early_sync();
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    n_cmp++;
    if ({sync_err, frame_done, locked, slot} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL early_sync_status got=%b want=%b", {sync_err, frame_done, locked, slot}, 5'b10101);
    end
    n_cmp++;
    if ({o1, o2, o3, o4} !== 32'h01020304) begin
      n_fail++;
      $display("FAIL early_sync_hold got=%h want=%h", {o1, o2, o3, o4}, 32'h01020304);
    end
    send(8'h40, 1'b0);
    send(8'h50, 1'b0);
    send(8'h60, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4, frame_done, sync_err} !== {32'h30405060, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL early_sync_commit got=%h fd=%b se=%b want=30405060 fd=1 se=0",
               {o1, o2, o3, o4}, frame_done, sync_err);
    end
  endtask

  task automatic test_slot0_loss();
    send(8'h99, 1'b0);
    n_cmp++;
    if ({sync_err, frame_done, locked, slot} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL loss_status got=%b want=%b", {sync_err, frame_done, locked, slot}, 5'b10000);
    end
    n_cmp++;
    if ({o1, o2, o3, o4} !== 32'h30405060) begin
      n_fail++;
      $display("FAIL loss_hold got=%h want=%h", {o1, o2, o3, o4}, 32'h30405060);
    end
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4, locked, frame_done} !== {32'hC1C2C3C4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL loss_relock got=%h lk=%b fd=%b want=c1c2c3c4 lk=1 fd=1",
               {o1, o2, o3, o4}, locked, frame_done);
    end
  endtask

  task automatic test_async_reset();
    send(8'hD1, 1'b1);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o1, o2, o3, o4, locked, slot} !== {32'h0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset got=%h lk=%b slot=%0d want=0", {o1, o2, o3, o4}, locked, slot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // A slot-3-position sample without sync must not commit stale data.
    send(8'hD4, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4, frame_done} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_no_stale got=%h fd=%b want=0", {o1, o2, o3, o4}, frame_done);
    end
    send(8'hE1, 1'b1);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send(8'hE4, 1'b0);
    n_cmp++;
    if ({o1, o2, o3, o4, frame_done} !== {32'hE1E2E3E4, 1'b1}) begin
      n_fail++;
      $display("FAIL async_recover got=%h fd=%b want=e1e2e3e4 fd=1", {o1, o2, o3, o4}, frame_done);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_hunt();
    test_early_sync();
    test_slot0_loss();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4.md
Name: tdm_demux_4

Overview:
- Receive-side counterpart of the 4:1 slot multiplexer: takes a time-division-multiplexed sample stream (slot order i1, i2, i3, i4) and redistributes it to four parallel channel outputs.
- Tracks slot position with a 2-bit counter qualified by a frame-sync marker.
- Double-buffers samples so all four outputs change together once per complete frame.
- Detects and recovers from sync loss.

Parameters:
- WIDTH, 1, bits per sample/channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  multiplexed sample.
- din_valid  input  1  din carries a sample this cycle.
- fsync  input  1  qualifies din as slot 0 (channel 1); ignored when din_valid=0.
- o1  output  WIDTH  channel 1 sample (slot 0).
- o2  output  WIDTH  channel 2 sample (slot 1).
- o3  output  WIDTH  channel 3 sample (slot 2).
- o4  output  WIDTH  channel 4 sample (slot 3).
- slot  output  2  next expected slot index, {s1,s0} encoding; 0 while hunting.
- locked  output  1  frame alignment held.
- frame_done  output  1  one-cycle pulse: o1..o4 updated this cycle.
- sync_err  output  1  one-cycle pulse: alignment violation detected.

Behaviour:
- Reset (rst_n low, async): o1..o4=0, holding regs h1..h3=0, slot=0, locked=0, frame_done=0, sync_err=0, state=HUNT.
- Cycles with din_valid=0: no state change; frame_done and sync_err forced 0. Gaps are legal anywhere within a frame.

State HUNT:
- Valid sample with fsync=0: dropped, no error.
- Valid sample with fsync=1: h1<=din, slot<=1, locked<=1, state<=LOCKED.

State LOCKED, valid sample, by current slot value:
- slot=0, fsync=1: h1<=din, slot<=1.
- slot=0, fsync=0: sample dropped, sync_err pulse, locked<=0, slot<=0, state<=HUNT.
- slot=1 or 2, fsync=0: h2 or h3 <=din, slot increments.
- slot=3, fsync=0:
  - Frame commit: o1<=h1, o2<=h2, o3<=h3, o4<=din, frame_done<=1.
  - slot wraps to 0.
- slot=1..3, fsync=1 (early sync): sync_err pulse, partial frame discarded (o1..o4 unchanged, no frame_done), h1<=din, slot<=1, stay LOCKED.

Latency and output rules:
- Outputs are registered.
- o1..o4 and frame_done update on the clock edge that accepts the slot-3 sample.
- o1..o4 never show a mixed old/new frame.
- o1..o4 hold their value between commits.
- frame_done and sync_err are never both 1.

Reset mid-frame:
- Holding regs cleared; partial frame lost.
- Outputs return to 0 immediately, not waiting for a clock edge.

Test Plan:
- WIDTH=8, reset then valid stream A0(fsync),A1,A2,A3 on consecutive cycles -> after A3 edge: o1..o4=A0,A1,A2,A3; frame_done high exactly 1 cycle; locked=1; slot=0.
- Two back-to-back frames 11,22,33,44 then 55,66,77,88 with din_valid gaps of 0-3 idle cycles inserted randomly -> o1..o4 hold 11/22/33/44 until 88 accepted, then switch atomically to 55/66/77/88; exactly 2 frame_done pulses.
- From HUNT, three valid samples with fsync=0 then a 4-sample frame starting with fsync=1 (values 01,02,03,04) -> first three samples ignored, no sync_err, o1..o4=01..04.
- While locked, send 10(fsync),20,30(fsync),40,50,60 -> sync_err pulse on the 30 edge, no frame_done for the partial frame; commit o1..o4=30,40,50,60.
- While locked at slot=0, send valid sample with fsync=0 -> sync_err pulse, locked=0, o1..o4 retain previous frame; a following fsync frame relocks and commits.
- Assert rst_n low asynchronously between clock edges after slot-2 sample -> o1..o4, slot, locked go 0 immediately; after release, a full frame commits correctly with no stale h-values.
